plru_tracker: RTL

PLRU_TRACKER -- requirements
Module: plru_tracker

---
 rtl/pkg_line.sv | 9 +
 rtl/plru_tracker_pkg.sv | 33 +++
 rtl/plru_tracker_if.sv | 43 ++++
 rtl/plru_tree_mem.sv | 32 +++
 rtl/plru_tracker.sv | 136 +++++++++++++
 5 files changed

// File: rtl/pkg_line.sv
// pkg_line: cache line geometry shared by the cache slice.
`default_nettype none

package pkg_line;
   localparam int N_WAY = 16;
   localparam int WAY_W = 4;
endpackage

`default_nettype wire

// File: rtl/plru_tracker_pkg.sv
// pkg_plru_trk: op/state encodings, tree width and the invalid-way picker.
// Macro: PLRU_INV_FIRST_EN (consumer of lowest_set). Revision 1.0
`default_nettype none

package pkg_plru_trk;
   import pkg_line::*;

   localparam int PLRU_W = N_WAY - 1;

   typedef enum logic {
      OP_UPDATE = 1'b0,
      OP_VICTIM = 1'b1
   } plru_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WALK  = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } trk_state_e;

   function automatic logic [WAY_W-1:0] lowest_set(input logic [N_WAY-1:0] mask);
      logic [WAY_W-1:0] idx;
      idx = '0;
      for (int i = N_WAY - 1; i >= 0; i--) begin
         if (mask[i]) idx = WAY_W'(i);
      end
      return idx;
   endfunction
endpackage

`default_nettype wire

// File: rtl/plru_tracker_if.sv
// plru_tracker_if: request/response bus of the PLRU tracker.
// Macro: PLRU_INV_FIRST_EN adds req_inv_mask. Revision 1.0
`default_nettype none

interface plru_tracker_if #(
   parameter int SET_W = 6
);
   import pkg_line::*;
   import pkg_plru_trk::*;

   logic                 req_valid;
   logic                 req_ready;
   plru_op_e             req_op;
   logic [SET_W-1:0]     req_set;
   logic [WAY_W-1:0]     req_way;
`ifdef PLRU_INV_FIRST_EN
   logic [N_WAY-1:0]     req_inv_mask;
`endif
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [WAY_W-1:0]     rsp_way;
   logic                 rsp_from_inv;

   modport master (
      output req_valid, req_op, req_set, req_way,
`ifdef PLRU_INV_FIRST_EN
      output req_inv_mask,
`endif
      output rsp_ready,
      input  req_ready, rsp_valid, rsp_way, rsp_from_inv
   );

   modport slave (
      input  req_valid, req_op, req_set, req_way,
`ifdef PLRU_INV_FIRST_EN
      input  req_inv_mask,
`endif
      input  rsp_ready,
      output req_ready, rsp_valid, rsp_way, rsp_from_inv
   );
endinterface

`default_nettype wire

// File: rtl/plru_tree_mem.sv
// plru_tree_mem: per-set PLRU rows, async clear, one async read and one write port.
// Revision 1.0
`default_nettype none

module plru_tree_mem #(
   parameter int SET_W = 6,
   parameter int ROW_W = 15
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic [SET_W-1:0] i_rd_addr,
   output logic      [ROW_W-1:0] o_rd_data,
   input  wire logic             i_wr_en,
   input  wire logic [SET_W-1:0] i_wr_addr,
   input  wire logic [ROW_W-1:0] i_wr_data
);
   localparam int N_SET = 2 ** SET_W;

   logic [ROW_W-1:0] r_rows [N_SET];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SET; i++) r_rows[i] <= '0;
      end else if (i_wr_en) begin
         r_rows[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_rows[i_rd_addr];
endmodule

`default_nettype wire

// File: rtl/plru_tracker.sv
// plru_tracker: 16-way tree-PLRU tracker, one tree level per cycle.
// Macro: PLRU_INV_FIRST_EN enables invalid-way-first victim selection. Revision 1.0
`default_nettype none

module plru_tracker
   import pkg_line::*;
   import pkg_plru_trk::*;
#(
   parameter int SET_W = 6
) (
   input wire logic     clk,
   input wire logic     rst_n,
   plru_tracker_if.slave bus
);
   trk_state_e        r_state, w_next;
   plru_op_e          r_op;
   logic [SET_W-1:0]  r_set;
   logic [WAY_W-1:0]  r_way, r_vic;
   logic [PLRU_W-1:0] r_row, w_rd_row;
   logic [1:0]        r_lvl;
   logic [3:0]        r_node;
   logic              w_bit, w_wr_en, w_req_ready, w_rsp_valid, w_rsp_from_inv;
   logic [WAY_W-1:0]  w_rsp_way;
`ifdef PLRU_INV_FIRST_EN
   logic [N_WAY-1:0]  r_mask;
   logic              r_from_inv;
`endif

   // Update copies the way bit of this level; victim walks against the node bit.
   assign w_bit = (r_op == OP_UPDATE) ? r_way[2'd3 - r_lvl] : ~r_row[r_node];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      w_req_ready    = 1'b0;
      w_rsp_valid    = 1'b0;
      w_rsp_way      = '0;
      w_rsp_from_inv = 1'b0;
      w_wr_en        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_req_ready = rst_n;
            if (bus.req_valid) w_next = ST_READ;
         end
         ST_READ:  w_next = ST_WALK;
         ST_WALK: begin
            if (r_lvl == 2'd3) w_next = (r_op == OP_UPDATE) ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: begin
            w_wr_en = 1'b1;
            w_next  = ST_IDLE;
         end
         ST_RESP: begin
            w_rsp_valid = 1'b1;
            w_rsp_way   = r_vic;
`ifdef PLRU_INV_FIRST_EN
            w_rsp_from_inv = r_from_inv;
`endif
            if (bus.rsp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= OP_UPDATE;
         r_set  <= '0;
         r_way  <= '0;
         r_vic  <= '0;
         r_row  <= '0;
         r_lvl  <= '0;
         r_node <= '0;
`ifdef PLRU_INV_FIRST_EN
         r_mask     <= '0;
         r_from_inv <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_op   <= bus.req_op;
                  r_set  <= bus.req_set;
                  r_way  <= bus.req_way;
                  r_vic  <= '0;
                  r_lvl  <= '0;
                  r_node <= '0;
`ifdef PLRU_INV_FIRST_EN
                  r_mask     <= bus.req_inv_mask;
                  r_from_inv <= 1'b0;
`endif
               end
            end
            ST_READ: r_row <= w_rd_row;
            ST_WALK: begin
               r_lvl  <= r_lvl + 2'd1;
               r_node <= {r_node[2:0], 1'b0} + 4'd1 + {3'd0, w_bit};
               if (r_op == OP_UPDATE) r_row[r_node] <= w_bit;
               else                   r_vic <= {r_vic[2:0], w_bit};
`ifdef PLRU_INV_FIRST_EN
               // An invalid way overrides the tree result on the final level.
               if (r_op == OP_VICTIM && r_lvl == 2'd3 && |r_mask) begin
                  r_vic      <= lowest_set(r_mask);
                  r_from_inv <= 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   plru_tree_mem #(
      .SET_W (SET_W),
      .ROW_W (PLRU_W)
   ) u_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_addr (r_set),
      .o_rd_data (w_rd_row),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_set),
      .i_wr_data (r_row)
   );

   assign bus.req_ready    = w_req_ready;
   assign bus.rsp_valid    = w_rsp_valid;
   assign bus.rsp_way      = w_rsp_way;
   assign bus.rsp_from_inv = w_rsp_from_inv;
endmodule

`default_nettype wire
